// File: rtl/pt_pkg.sv
// pt_pkg: shared definitions for the PT2262-style frame encoder.
// Holds the trit pair codes, the alpha-period timing constants and the
// FSM state encoding used by pt_frame_enc.
// No ports (package).

package pt_pkg;

  // Two-bit trit codes as they appear in the code word (01 and 10 both mean F)
  localparam logic [1:0] TRIT_0 = 2'b00;
  localparam logic [1:0] TRIT_1 = 2'b11;
  localparam logic [1:0] TRIT_F = 2'b01;

  // Pulse widths in units of the oscillator period alpha
  localparam int A_SHORT = 4;
  localparam int A_LONG  = 12;
  localparam int A_HALF  = 16;
  localparam int A_SYM   = 32;
  localparam int A_SYNC  = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CODE = 2'd1,
    SYNC = 2'd2
  } state_t;

endpackage

// File: rtl/pt_alpha_tick.sv
// pt_alpha_tick: alpha-clock prescaler.
// Emits a one-cycle tick every ALPHA_DIV clocks while not cleared.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset
//   clr   - holds the prescaler at count 0 (used while the encoder is idle)
//   tick  - high on the last clock of each alpha period

module pt_alpha_tick #(
  parameter int ALPHA_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (ALPHA_DIV > 1) ? $clog2(ALPHA_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  // Tick is decoded from the registered count, so the first alpha period after
  // a clear is a full ALPHA_DIV clocks long.
  assign tick = (cnt == CNT_W'(ALPHA_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pt_frame_enc.sv
// pt_frame_enc: parametrised PT2262-style frame encoder.
// Captures a TRITS-trit code word on a load strobe and sends it REPEAT times,
// each frame being the trits (MSB pair first) followed by a sync symbol,
// using pulse-width coding timed by an alpha period of ALPHA_DIV clocks.
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset
//   ld    - load strobe, honoured only while idle
//   ad    - code word, 2 bits per trit
//   q     - registered encoded serial output
//   busy  - high while frames are being sent
//   done  - one-cycle pulse in the first idle cycle after the last frame
// Configuration macro: PT_TRISTATE_EN enables full tri-state (F) decoding;
// without it each trit is taken from the upper bit of its pair.

module pt_frame_enc
  import pt_pkg::*;
#(
  parameter int TRITS     = 12,
  parameter int ALPHA_DIV = 1,
  parameter int REPEAT    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld,
  input  logic [2*TRITS-1:0] ad,
  output logic               q,
  output logic               busy,
  output logic               done
);

  localparam int IDX_W = (TRITS > 1) ? $clog2(TRITS) : 1;
  localparam int REP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;

  state_t             state;
  logic [IDX_W-1:0]   trit_idx;
  logic [REP_W-1:0]   rep_cnt;
  logic [6:0]         alpha_cnt;
  logic [6:0]         alpha_nxt;
  logic [2*TRITS-1:0] word;
  logic [1:0]         cur_pair;
  logic [1:0]         cur_trit;
  logic               tick;

  pt_alpha_tick #(.ALPHA_DIV(ALPHA_DIV)) u_alpha_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == IDLE),
    .tick (tick)
  );

  assign alpha_nxt = alpha_cnt + 7'd1;
  assign cur_pair  = word[2*trit_idx +: 2];

`ifdef PT_TRISTATE_EN
  assign cur_trit = cur_pair;

  // High time of one half-cycle; F behaves as 0 in the first half and as 1 in
  // the second half.
  function automatic logic [4:0] high_len(input logic [1:0] t, input logic second_half);
    case (t)
      TRIT_0:  high_len = 5'(A_SHORT);
      TRIT_1:  high_len = 5'(A_LONG);
      default: high_len = second_half ? 5'(A_LONG) : 5'(A_SHORT);
    endcase
  endfunction
`else
  logic unused_lsb;
  assign unused_lsb = cur_pair[0];
  assign cur_trit   = {cur_pair[1], cur_pair[1]};

  function automatic logic [4:0] high_len(input logic [1:0] t, input logic second_half);
    logic unused_half;
    unused_half = second_half;
    high_len = t[1] ? 5'(A_LONG) : 5'(A_SHORT);
  endfunction
`endif

  // Level for position a of a trit: bit 4 selects the half (a >= A_HALF),
  // bits 3:0 are the position inside that half.
  function automatic logic code_level(input logic [1:0] t, input logic [6:0] a);
    code_level = ({1'b0, a[3:0]} < high_len(t, a[4]));
  endfunction

  // Single FSM: q is assigned the level of the alpha position being entered,
  // so it is registered and aligned with the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      trit_idx  <= '0;
      rep_cnt   <= '0;
      alpha_cnt <= '0;
      word      <= '0;
      q         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          q    <= 1'b0;
          busy <= 1'b0;
          if (ld) begin
            word      <= ad;
            state     <= CODE;
            trit_idx  <= IDX_W'(TRITS - 1);
            rep_cnt   <= '0;
            alpha_cnt <= '0;
            busy      <= 1'b1;
            q         <= 1'b1;
          end
        end
        CODE: begin
          if (tick) begin
            if (alpha_cnt == 7'(A_SYM - 1)) begin
              // Every trit and the sync symbol start with a high phase
              alpha_cnt <= '0;
              q         <= 1'b1;
              if (trit_idx == '0) begin
                state <= SYNC;
              end else begin
                trit_idx <= trit_idx - 1'b1;
              end
            end else begin
              alpha_cnt <= alpha_nxt;
              q         <= code_level(cur_trit, alpha_nxt);
            end
          end
        end
        SYNC: begin
          if (tick) begin
            if (alpha_cnt == 7'(A_SYNC - 1)) begin
              alpha_cnt <= '0;
              if (rep_cnt == REP_W'(REPEAT - 1)) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
                q     <= 1'b0;
              end else begin
                rep_cnt  <= rep_cnt + 1'b1;
                trit_idx <= IDX_W'(TRITS - 1);
                state    <= CODE;
                q        <= 1'b1;
              end
            end else begin
              alpha_cnt <= alpha_nxt;
              q         <= (alpha_nxt < 7'(A_SHORT));
            end
          end
        end
        default: begin
          state <= IDLE;
          q     <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pt_frame_enc.sv
// tb_pt_frame_enc: directed self-checking bench for pt_frame_enc.
// Instance a: TRITS=4, ALPHA_DIV=1, REPEAT=2. Instance b: TRITS=1,
// ALPHA_DIV=3, REPEAT=1. The q waveform is recorded as run lengths while
// busy is high and compared against hand-computed run tables.

module tb_pt_frame_enc;

  logic       clk = 1'b0;
  logic       rst;
  logic       ld_a, ld_b;
  logic [7:0] ad_a;
  logic [1:0] ad_b;
  logic       q_a, busy_a, done_a;
  logic       q_b, busy_b, done_b;

  int compared   = 0;
  int mismatched = 0;
  int got_runs[0:63];
  int exp_runs[$];

  always #5 clk = ~clk;

  pt_frame_enc #(.TRITS(4), .ALPHA_DIV(1), .REPEAT(2)) u_dut_a (
    .clk  (clk),
    .rst  (rst),
    .ld   (ld_a),
    .ad   (ad_a),
    .q    (q_a),
    .busy (busy_a),
    .done (done_a)
  );

  pt_frame_enc #(.TRITS(1), .ALPHA_DIV(3), .REPEAT(1)) u_dut_b (
    .clk  (clk),
    .rst  (rst),
    .ld   (ld_b),
    .ad   (ad_b),
    .q    (q_b),
    .busy (busy_b),
    .done (done_b)
  );

  // One comparison: counts it and reports a failure with tag and values
  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive a load strobe on one instance for exactly one clock edge
  task automatic applyStimulus(input int sel, input logic [7:0] word);
    if (sel == 0) begin
      ld_a = 1'b1;
      ad_a = word;
    end else begin
      ld_b = 1'b1;
      ad_b = word[1:0];
    end
    @(negedge clk);
    ld_a = 1'b0;
    ld_b = 1'b0;
  endtask

  // Record q run lengths while busy is high; optionally pulse ld on instance a
  // at busy cycle inject_at with a different word.
  task automatic captureRuns(input int sel, input int inject_at, input logic [7:0] inject_ad,
                             output int busy_len, output int nruns);
    int   run;
    logic prev;
    logic cq;
    busy_len = 0;
    nruns    = 0;
    run      = 0;
    prev     = (sel == 0) ? q_a : q_b;
    while ((((sel == 0) ? busy_a : busy_b) === 1'b1) && (busy_len < 2000)) begin
      cq = (sel == 0) ? q_a : q_b;
      if (cq !== prev) begin
        if (nruns < 64) got_runs[nruns] = run;
        nruns++;
        run  = 0;
        prev = cq;
      end
      run++;
      busy_len++;
      if (sel == 0) begin
        if (busy_len == inject_at) begin
          ld_a = 1'b1;
          ad_a = inject_ad;
        end else begin
          ld_a = 1'b0;
        end
      end
      @(negedge clk);
    end
    if (nruns < 64) got_runs[nruns] = run;
    nruns++;
  endtask

  task automatic checkRuns(input string tag, input int nruns);
    checkOutput({tag, " run count"}, nruns, exp_runs.size());
    for (int i = 0; i < nruns && i < exp_runs.size() && i < 64; i++) begin
      checkOutput($sformatf("%s run %0d", tag, i), got_runs[i], exp_runs[i]);
    end
  endtask

  // Expected runs for ad = 00_11_01_00, two frames
  task automatic buildRunsA();
    exp_runs.delete();
    for (int f = 0; f < 2; f++) begin
      exp_runs.push_back(4);  exp_runs.push_back(12); exp_runs.push_back(4);  exp_runs.push_back(12);
      exp_runs.push_back(12); exp_runs.push_back(4);  exp_runs.push_back(12); exp_runs.push_back(4);
`ifdef PT_TRISTATE_EN
      exp_runs.push_back(4);  exp_runs.push_back(12); exp_runs.push_back(12); exp_runs.push_back(4);
`else
      exp_runs.push_back(4);  exp_runs.push_back(12); exp_runs.push_back(4);  exp_runs.push_back(12);
`endif
      exp_runs.push_back(4);  exp_runs.push_back(12); exp_runs.push_back(4);  exp_runs.push_back(12);
      exp_runs.push_back(4);  exp_runs.push_back(124);
    end
  endtask

  initial begin
    int blen;
    int nr;
    int n;
    int hits;

    rst  = 1'b1;
    ld_a = 1'b0;
    ld_b = 1'b0;
    ad_a = '0;
    ad_b = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset q_a", q_a, 0);
    checkOutput("reset busy_a", busy_a, 0);
    checkOutput("reset done_a", done_a, 0);
    checkOutput("reset q_b", q_b, 0);
    checkOutput("reset busy_b", busy_b, 0);
    checkOutput("reset done_b", done_b, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] basic two-frame transfer");
    buildRunsA();
    applyStimulus(0, 8'b00_11_01_00);
    checkOutput("t1 start busy", busy_a, 1);
    checkOutput("t1 start q", q_a, 1);
    captureRuns(0, 0, 8'h00, blen, nr);
    checkOutput("t1 busy length", blen, 512);
    checkOutput("t1 done", done_a, 1);
    checkOutput("t1 q in done", q_a, 0);
    checkRuns("t1", nr);
    @(negedge clk);
    checkOutput("t1 done cleared", done_a, 0);
    checkOutput("t1 stays idle", busy_a, 0);

    $display("[TB] load during busy is ignored");
    applyStimulus(0, 8'b00_11_01_00);
    captureRuns(0, 100, 8'hFF, blen, nr);
    checkOutput("t2 busy length", blen, 512);
    checkOutput("t2 done", done_a, 1);
    checkRuns("t2", nr);
    @(negedge clk);
    checkOutput("t2 done single", done_a, 0);
    checkOutput("t2 no requeue", busy_a, 0);

    $display("[TB] reset mid-transfer");
    applyStimulus(0, 8'b00_11_01_00);
    repeat (299) @(negedge clk);
    checkOutput("t3 busy before reset", busy_a, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t3 q after reset", q_a, 0);
    checkOutput("t3 busy after reset", busy_a, 0);
    checkOutput("t3 done after reset", done_a, 0);
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_a === 1'b1 || busy_a === 1'b1) hits++;
    end
    checkOutput("t3 quiet after reset", hits, 0);
    applyStimulus(0, 8'b00_11_01_00);
    captureRuns(0, 0, 8'h00, blen, nr);
    checkOutput("t3 clean busy length", blen, 512);
    checkRuns("t3", nr);
    @(negedge clk);

    $display("[TB] reset and load together");
    rst  = 1'b1;
    ld_a = 1'b1;
    ad_a = 8'hFF;
    @(negedge clk);
    rst  = 1'b0;
    ld_a = 1'b0;
    checkOutput("t4 load dropped busy", busy_a, 0);
    checkOutput("t4 load dropped q", q_a, 0);
    @(negedge clk);
    checkOutput("t4 still idle", busy_a, 0);

    $display("[TB] ld held high");
    ld_a = 1'b1;
    ad_a = 8'b00_11_01_00;
    @(negedge clk);
    checkOutput("t5 first busy", busy_a, 1);
    n = 0;
    while (busy_a === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    checkOutput("t5 first length", n, 512);
    checkOutput("t5 idle done", done_a, 1);
    checkOutput("t5 idle q", q_a, 0);
    @(negedge clk);
    checkOutput("t5 retrigger busy", busy_a, 1);
    checkOutput("t5 retrigger q", q_a, 1);
    checkOutput("t5 retrigger done", done_a, 0);
    n = 0;
    while (busy_a === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    checkOutput("t5 second length", n, 512);
    checkOutput("t5 second done", done_a, 1);
    ld_a = 1'b0;
    @(negedge clk);
    checkOutput("t5 released idle", busy_a, 0);

    $display("[TB] ALPHA_DIV=3 single trit");
    exp_runs.delete();
    exp_runs.push_back(36); exp_runs.push_back(12);
    exp_runs.push_back(36); exp_runs.push_back(12);
    exp_runs.push_back(12); exp_runs.push_back(372);
    applyStimulus(1, 8'b0000_0011);
    checkOutput("t6 start busy", busy_b, 1);
    checkOutput("t6 start q", q_b, 1);
    captureRuns(1, 0, 8'h00, blen, nr);
    checkOutput("t6 busy length", blen, 480);
    checkOutput("t6 done", done_b, 1);
    checkOutput("t6 q in done", q_b, 0);
    checkRuns("t6", nr);
    @(negedge clk);
    checkOutput("t6 done cleared", done_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
